// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// address/data types and the hardwired-zero register address.
package reg_file_pkg;

  localparam int unsigned DEF_ADW = 5;
  localparam int unsigned DEF_DPW = 32;
  localparam int unsigned DEF_NRP = 2;
  localparam int unsigned DEF_NWP = 1;

  typedef logic [DEF_ADW-1:0] reg_addr_t;
  typedef logic [DEF_DPW-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/reg_file_mp_if.sv
// Read, write and reservation bus of the multi-port register file.
// master = decode/issue + writeback side, slave = the register file.
interface reg_file_mp_if #(
  parameter int unsigned ADW = 5,
  parameter int unsigned DPW = 32,
  parameter int unsigned NRP = 2,
  parameter int unsigned NWP = 1
);
  logic [NRP-1:0]           rd_en;
  logic [NRP-1:0][ADW-1:0]  rd_addr;
  logic [NRP-1:0][DPW-1:0]  rd_data;
  logic [NRP-1:0]           rd_busy;
  logic [NWP-1:0]           we;
  logic [NWP-1:0][ADW-1:0]  wa;
  logic [NWP-1:0][DPW-1:0]  wd;
  logic                     rsv_en;
  logic [ADW-1:0]           rsv_addr;

  modport master (
    output rd_en, rd_addr, we, wa, wd, rsv_en, rsv_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, we, wa, wd, rsv_en, rsv_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Busy scoreboard: one pending-writeback bit per register, write-clear /
// reserve-set priority and per-read-port busy lookup (REG_FILE_BYPASS_EN).
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADW      = DEF_ADW,
  parameter int unsigned NRP      = DEF_NRP,
  parameter int unsigned NWP      = DEF_NWP,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [NWP-1:0]          clr_en,
  input  logic [NWP-1:0][ADW-1:0] clr_addr,
  input  logic                    set_en,
  input  logic [ADW-1:0]          set_addr,
  input  logic [NRP-1:0][ADW-1:0] look_addr,
  output logic [NRP-1:0]          look_busy
);

  localparam int unsigned DEPTH = 1 << ADW;
  localparam logic [ADW-1:0] ZA = ADW'(ZERO_ADDR);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Reservation is applied after the clears so it wins on the same address.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned k = 0; k < NWP; k++) begin
      if (clr_en[k]) busy_nxt[clr_addr[k]] = 1'b0;
    end
    if (set_en) busy_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) busy <= '0;
    else         busy <= busy_nxt;
  end

  always_comb begin
    look_busy = '0;
    for (int unsigned i = 0; i < NRP; i++) begin
`ifdef REG_FILE_BYPASS_EN
      look_busy[i] = busy_nxt[look_addr[i]];
`else
      look_busy[i] = busy[look_addr[i]];
`endif
      if ((ZERO_REG != 0) && (look_addr[i] == ZA)) look_busy[i] = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with busy scoreboard and optional
// hardwired zero. Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned ADW      = DEF_ADW,
  parameter int unsigned DPW      = DEF_DPW,
  parameter int unsigned NRP      = DEF_NRP,
  parameter int unsigned NWP      = DEF_NWP,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  reg_file_mp_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADW;
  localparam logic [ADW-1:0] ZA = ADW'(ZERO_ADDR);

  if (NRP < 1 || NRP > 4) begin : g_bad_nrp
    $fatal(1, "reg_file_mp: NRP must be 1..4");
  end
  if (NWP < 1 || NWP > 2) begin : g_bad_nwp
    $fatal(1, "reg_file_mp: NWP must be 1..2");
  end
  if (ZERO_REG > 1) begin : g_bad_zero
    $fatal(1, "reg_file_mp: ZERO_REG must be 0 or 1");
  end
  if (ADW < 1 || DPW < 1) begin : g_bad_width
    $fatal(1, "reg_file_mp: ADW and DPW must be nonzero");
  end

  logic [DPW-1:0]          regs [DEPTH];
  logic [NWP-1:0]          we_eff;
  logic                    rsv_eff;
  logic [NRP-1:0][DPW-1:0] rd_nxt;
  logic [NRP-1:0]          busy_look;

  always_comb begin
    we_eff = '0;
    for (int unsigned k = 0; k < NWP; k++) begin
      we_eff[k] = bus.we[k] && !((ZERO_REG != 0) && (bus.wa[k] == ZA));
    end
    rsv_eff = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == ZA));
  end

  // Ascending port order: the highest-index write to an address lands last.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned a = 0; a < DEPTH; a++) regs[a] <= '0;
    end else begin
      for (int unsigned k = 0; k < NWP; k++) begin
        if (we_eff[k]) regs[bus.wa[k]] <= bus.wd[k];
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    for (int unsigned i = 0; i < NRP; i++) begin
      rd_nxt[i] = regs[bus.rd_addr[i]];
`ifdef REG_FILE_BYPASS_EN
      for (int unsigned k = 0; k < NWP; k++) begin
        if (we_eff[k] && (bus.wa[k] == bus.rd_addr[i])) rd_nxt[i] = bus.wd[k];
      end
`endif
      if ((ZERO_REG != 0) && (bus.rd_addr[i] == ZA)) rd_nxt[i] = '0;
    end
  end

  reg_file_scoreboard #(
    .ADW      (ADW),
    .NRP      (NRP),
    .NWP      (NWP),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr_en    (we_eff),
    .clr_addr  (bus.wa),
    .set_en    (rsv_eff),
    .set_addr  (bus.rsv_addr),
    .look_addr (bus.rd_addr),
    .look_busy (busy_look)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.rd_data <= '0;
      bus.rd_busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NRP; i++) begin
        if (bus.rd_en[i]) begin
          bus.rd_data[i] <= rd_nxt[i];
          bus.rd_busy[i] <= busy_look[i];
        end
      end
    end
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the RISC-V core. It replaces the single-write, dual-read register file with configurable read and write port counts, per-port read enables, and a hardwired-zero option. It also includes a busy scoreboard so the issue stage can detect pending writebacks. It sits between decode/issue (reads, reservations) and writeback (writes).

## Interface
- ADW, 5, address width; depth = 2**ADW
- DPW, 32, data width
- NRP, 2, number of read ports (1..4)
- NWP, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and reservations
- clk  in  1  clock, all state on rising edge
- arst_n  in  1  asynchronous active-low reset
- rd_en  in  NRP  per-port read enable
- rd_addr  in  NRP x ADW  read addresses
- rd_data  out  NRP x DPW  registered read data
- rd_busy  out  NRP  registered busy flag of the addressed register
- we  in  NWP  per-port write enable
- wa  in  NWP x ADW  write addresses
- wd  in  NWP x DPW  write data
- rsv_en  in  1  mark rsv_addr busy (pending writeback)
- rsv_addr  in  ADW  register to reserve

## Operation
- Reset is asserted asynchronously and released synchronously by the integrating design. It clears all 2**ADW registers, all busy bits, rd_data and rd_busy to 0.
- Write: on an edge with we[k]=1, regs[wa[k]] <= wd[k] and busy[wa[k]] <= 0.
- Write/write collision: several write ports target the same address in one cycle. The highest port index wins for data; the busy bit is cleared.
- Reservation: on an edge with rsv_en=1, busy[rsv_addr] <= 1. If a reservation and a write target the same address in one cycle, the reservation wins: data is written and busy ends at 1.
- Read: on an edge with rd_en[i]=1, rd_data[i] <= regs[rd_addr[i]] and rd_busy[i] <= busy[rd_addr[i]]. With rd_en[i]=0, both outputs hold their values.
- ZERO_REG=1, address 0:
  - writes are dropped;
  - reservations are dropped;
  - a read returns rd_data=0 and rd_busy=0, regardless of bypass.
- Unused or out-of-range parameter combinations are a build-time assertion failure.

## Timing
- Read latency: 1 cycle, from rd_en/rd_addr sampled to rd_data valid.
- Write latency: 1 cycle. Data is visible to a read issued in the cycle after the write edge.
- Same-cycle read and write to the same address: behaviour depends on the configuration macro (see below).
- Busy set/clear takes effect at the edge. rd_busy follows the same forwarding rule as rd_data.
- Reset mid-operation: all state clears immediately on arst_n falling, with no dependence on clk. The first write or read after release behaves as if from power-up.

## Configuration
- REG_FILE_BYPASS_EN defined: a read and a write to the same nonzero address in the same cycle return the new data (highest-index write port) and the post-update busy value.
- REG_FILE_BYPASS_EN undefined: the same case returns the old data and old busy value. The writeback stage must then stall or forward externally.

## Structure
- Shared package reg_file_pkg holds:
  - localparams for default ADW/DPW/NRP/NWP;
  - typedefs reg_addr_t and reg_data_t;
  - constant ZERO_ADDR.
- One sub-module, reg_file_scoreboard, owns the 2**ADW busy vector. It handles set/clear priority and the per-port busy lookup, including the bypass path.
- The storage array and write-port priority stay in the top.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse arst_n low between edges, then read r5 -> rd_data=0 and rd_busy=0 one cycle after rd_en.
- Basic write/read, NRP=2: write r3=0x12345678, then next cycle read ports r3 and r0 -> rd_data[0]=0x12345678, rd_data[1]=0; with rd_en low afterwards, outputs hold.
- Zero register: write r0=0xFFFFFFFF and reserve r0 -> read r0 gives data 0 and busy 0.
- Same-address collision, NWP=2: we[0] writes r7=0x1, we[1] writes r7=0x2 -> read r7 returns 0x2.
- Bypass: read r9 while writing r9=0xA5A5A5A5 (old value 0):
  - with REG_FILE_BYPASS_EN -> 0xA5A5A5A5;
  - without -> 0, then 0xA5A5A5A5 on the next read.
- Scoreboard:
  - reserve r4 -> next read shows busy=1;
  - write r4 -> busy=0;
  - reserve and write r4 in the same cycle -> busy=1 and data updated.
